// File: rtl/regfile_wb_ctrl.sv
// Write-side controller for the integer register file: round-robin arbitration of
// EXU/LSU results onto the single write port, plus a per-register pending scoreboard.
module regfile_wb_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NREG       = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_wen,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] chk_rs1,
  input  logic [ADDR_WIDTH-1:0] chk_rs2,
  output logic                  chk_busy,
  input  logic                  exu_valid,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  output logic                  exu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_t;

  src_t                  rr_last;
  logic [NREG-1:0]       pending;
  logic [NREG-1:0]       pending_next;
  logic                  grant_exu;
  logic                  grant_lsu;
  logic                  issue_fire;
  logic [ADDR_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0] win_data;

  assign chk_busy    = pending[chk_rs1] | pending[chk_rs2];
  assign issue_ready = ~(issue_wen & pending[issue_rd]);
  assign issue_fire  = issue_valid & issue_ready;

  // On contention the source that did not win last time gets the port.
  assign grant_exu = exu_valid & (~lsu_valid | (rr_last == SRC_LSU));
  assign grant_lsu = lsu_valid & (~exu_valid | (rr_last == SRC_EXU));
  assign exu_ready = grant_exu;
  assign lsu_ready = grant_lsu;

  always_comb begin
    win_rd   = exu_rd;
    win_data = exu_data;
    if (grant_lsu) begin
      win_rd   = lsu_rd;
      win_data = lsu_data;
    end
  end

  // Clear is applied before set so a same-edge set of the same index wins.
  always_comb begin
    pending_next = pending;
    if (rf_wen) begin
      pending_next[rf_waddr] = 1'b0;
    end
    if (issue_fire && issue_wen && (issue_rd != '0)) begin
      pending_next[issue_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      rr_last  <= SRC_EXU;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      pending <= pending_next;
      rf_wen  <= 1'b0;
      if (grant_exu) begin
        rr_last <= SRC_EXU;
      end else if (grant_lsu) begin
        rr_last <= SRC_LSU;
      end
      if ((grant_exu || grant_lsu) && (win_rd != '0)) begin
        rf_wen   <= 1'b1;
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed testbench for regfile_wb_ctrl: scoreboard, round-robin arbitration,
// write-port timing and reset behaviour, checked with immediate assertions.
module tb_regfile_wb_ctrl;

  localparam int AW = 5;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid;
  logic          issue_wen;
  logic [AW-1:0] issue_rd;
  logic          issue_ready;
  logic [AW-1:0] chk_rs1;
  logic [AW-1:0] chk_rs2;
  logic          chk_busy;
  logic          exu_valid;
  logic [AW-1:0] exu_rd;
  logic [DW-1:0] exu_data;
  logic          exu_ready;
  logic          lsu_valid;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          lsu_ready;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  regfile_wb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_busy(chk_busy),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ev, input logic [AW-1:0] erd, input logic [DW-1:0] edata,
                               input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldata);
    exu_valid = ev;
    exu_rd    = erd;
    exu_data  = edata;
    lsu_valid = lv;
    lsu_rd    = lrd;
    lsu_data  = ldata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBusy(input string tag, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                           input logic expected);
    chk_rs1 = rs1;
    chk_rs2 = rs2;
    #1;
    checkOutput(tag, {63'd0, chk_busy}, {63'd0, expected});
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_rd    = rd;
    tick();
    issue_valid = 1'b0;
    issue_wen   = 1'b0;
    issue_rd    = '0;
  endtask

  task automatic checkWrite(input string tag, input logic wen, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data);
    checkOutput({tag, "_wen"}, {63'd0, rf_wen}, {63'd0, wen});
    checkOutput({tag, "_waddr"}, {59'd0, rf_waddr}, {59'd0, addr});
    checkOutput({tag, "_wdata"}, rf_wdata, data);
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0;
    issue_wen   = 1'b0;
    issue_rd    = '0;
    chk_rs1     = '0;
    chk_rs2     = '0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
    $display("[TB] reset released");

    checkWrite("reset", 1'b0, 5'd0, 64'd0);
    checkBusy("reset_busy", 5'd5, 5'd9, 1'b0);
    issue_wen = 1'b1;
    issue_rd  = 5'd5;
    #1;
    checkOutput("reset_issue_ready", {63'd0, issue_ready}, 64'd1);
    issue_wen = 1'b0;

    // Issue rd=5: scoreboard marks it, WAW issue stalls.
    issue(5'd5);
    checkBusy("rd5_busy_rs1", 5'd5, 5'd0, 1'b1);
    checkBusy("rd5_busy_rs2", 5'd0, 5'd5, 1'b1);
    checkBusy("rd6_not_busy", 5'd6, 5'd4, 1'b0);
    issue_valid = 1'b1;
    issue_wen   = 1'b1;
    issue_rd    = 5'd5;
    #1;
    checkOutput("rd5_waw_stall", {63'd0, issue_ready}, 64'd0);
    issue_wen = 1'b0;
    #1;
    checkOutput("rd5_nowen_ready", {63'd0, issue_ready}, 64'd1);
    issue_valid = 1'b0;

    // EXU result for rd=5 -> write next cycle -> busy drops the cycle after.
    applyStimulus(1'b1, 5'd5, 64'h1234, 1'b0, '0, '0);
    checkOutput("exu5_ready", {63'd0, exu_ready}, 64'd1);
    checkOutput("exu5_lsu_ready", {63'd0, lsu_ready}, 64'd0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkWrite("exu5_write", 1'b1, 5'd5, 64'h1234);
    checkBusy("exu5_busy_write_cycle", 5'd5, 5'd0, 1'b1);
    tick();
    checkOutput("exu5_wen_drop", {63'd0, rf_wen}, 64'd0);
    checkBusy("exu5_busy_cleared", 5'd5, 5'd0, 1'b0);

    // Contention: rr_last is EXU, so grants go LSU(7), EXU(3), LSU(8).
    applyStimulus(1'b1, 5'd3, 64'h33, 1'b1, 5'd7, 64'h77);
    checkOutput("rr1_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    checkOutput("rr1_exu_ready", {63'd0, exu_ready}, 64'd0);
    tick();
    checkWrite("rr1_write", 1'b1, 5'd7, 64'h77);
    applyStimulus(1'b1, 5'd3, 64'h33, 1'b1, 5'd8, 64'h88);
    checkOutput("rr2_exu_ready", {63'd0, exu_ready}, 64'd1);
    checkOutput("rr2_lsu_ready", {63'd0, lsu_ready}, 64'd0);
    tick();
    checkWrite("rr2_write", 1'b1, 5'd3, 64'h33);
    applyStimulus(1'b1, 5'd4, 64'h44, 1'b1, 5'd8, 64'h88);
    checkOutput("rr3_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    checkOutput("rr3_exu_ready", {63'd0, exu_ready}, 64'd0);
    tick();
    checkWrite("rr3_write", 1'b1, 5'd8, 64'h88);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    tick();
    checkOutput("rr_idle_wen", {63'd0, rf_wen}, 64'd0);
    checkOutput("rr_idle_waddr_hold", {59'd0, rf_waddr}, 64'd8);

    // Result to x0 is consumed without a write; issuing x0 sets nothing.
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 64'hdead);
    checkOutput("x0_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("x0_no_wen", {63'd0, rf_wen}, 64'd0);
    checkBusy("x0_pending_unchanged", 5'd7, 5'd3, 1'b0);
    issue(5'd0);
    checkBusy("x0_never_pending", 5'd0, 5'd0, 1'b0);

    // Reset with pending entries and an in-flight EXU result.
    issue(5'd9);
    issue(5'd10);
    checkBusy("pre_rst_busy9", 5'd9, 5'd0, 1'b1);
    checkBusy("pre_rst_busy10", 5'd0, 5'd10, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b1, 5'd9, 64'h99, 1'b0, '0, '0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkWrite("post_rst", 1'b0, 5'd0, 64'd0);
    checkBusy("post_rst_busy", 5'd9, 5'd10, 1'b0);

    // rr_last returns to EXU on reset, so contention grants LSU first.
    applyStimulus(1'b1, 5'd11, 64'hb1, 1'b1, 5'd12, 64'hc2);
    checkOutput("post_rst_rr_lsu", {63'd0, lsu_ready}, 64'd1);
    checkOutput("post_rst_rr_exu", {63'd0, exu_ready}, 64'd0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkWrite("post_rst_rr_write", 1'b1, 5'd12, 64'hc2);
    tick();

    // Back-to-back EXU writes to rd=1 then rd=2.
    issue(5'd1);
    issue(5'd2);
    applyStimulus(1'b1, 5'd1, 64'h11, 1'b0, '0, '0);
    checkOutput("b2b1_exu_ready", {63'd0, exu_ready}, 64'd1);
    tick();
    applyStimulus(1'b1, 5'd2, 64'h22, 1'b0, '0, '0);
    checkOutput("b2b2_exu_ready", {63'd0, exu_ready}, 64'd1);
    checkWrite("b2b1_write", 1'b1, 5'd1, 64'h11);
    checkBusy("b2b1_busy12", 5'd1, 5'd2, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkWrite("b2b2_write", 1'b1, 5'd2, 64'h22);
    checkBusy("b2b_rd1_cleared", 5'd1, 5'd0, 1'b0);
    checkBusy("b2b_rd2_still_busy", 5'd0, 5'd2, 1'b1);
    tick();
    checkOutput("b2b_wen_drop", {63'd0, rf_wen}, 64'd0);
    checkBusy("b2b_rd2_cleared", 5'd2, 5'd1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
